// File: rtl/g_ram_writer.sv
// g_ram_writer: capture buffer behind the counter-to-g_clk synchroniser.
// Packs each g_valid event as {diff_count, diff} into an internal RAM.
// The RAM has a single write port and a registered read.
// Capture is armed, filled and stopped by a small state machine.
// The stored events are then read out sequentially through g_rd_start / g_rd_en.
//
// state      | meaning
// -----------+------------------------------------------------------------
// ST_IDLE    | buffer quiescent; events ignored, counters hold last capture
// ST_CAPTURE | each g_valid is written at g_wr_count and counted
// ST_DONE    | capture closed (full or stopped); events count as drops
// ST_READOUT | g_rd_en streams stored words; last word returns to IDLE

module g_ram_writer #(
    parameter int DATASIZE  = 16,
    parameter int COUNTSIZE = 32,
    parameter int ADDRWIDTH = 10
) (
    input  logic                          g_clk,
    input  logic                          g_rst,
    input  logic                          g_valid,
    input  logic [DATASIZE-1:0]           g_sync2_diff,
    input  logic [COUNTSIZE-1:0]          g_sync2_diff_count,
    input  logic                          g_arm,
    input  logic                          g_stop,
    input  logic                          g_rd_start,
    input  logic                          g_rd_en,
    output logic [1:0]                    g_state,
    output logic [ADDRWIDTH:0]            g_wr_count,
    output logic                          g_full,
    output logic [15:0]                   g_drop_count,
    output logic [DATASIZE+COUNTSIZE-1:0] g_rd_data,
    output logic                          g_rd_valid,
    output logic                          g_rd_done
);

    localparam int WORDSIZE = DATASIZE + COUNTSIZE;
    localparam int DEPTH    = 1 << ADDRWIDTH;
    localparam logic [ADDRWIDTH:0] DEPTH_CNT = (ADDRWIDTH+1)'(DEPTH);
    localparam logic [ADDRWIDTH:0] ONE_CNT   = (ADDRWIDTH+1)'(1);
    localparam logic [15:0]        DROP_MAX  = 16'hFFFF;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_DONE    = 2'd2,
        ST_READOUT = 2'd3
    } state_t;

    state_t                state;
    logic [WORDSIZE-1:0]   mem [DEPTH];
    logic [ADDRWIDTH:0]    rd_ptr;
    logic [ADDRWIDTH:0]    wr_count_inc;
    logic [ADDRWIDTH:0]    last_addr;
    logic [WORDSIZE-1:0]   wr_word;
    logic                  wr_en;
    logic                  drop_inc;
    logic                  start_capture;

    assign g_state       = state;
    assign wr_word       = {g_sync2_diff_count, g_sync2_diff};
    assign wr_en         = (state == ST_CAPTURE) && g_valid;
    assign wr_count_inc  = g_wr_count + ONE_CNT;
    assign last_addr     = g_wr_count - ONE_CNT;
    assign drop_inc      = g_valid && (g_drop_count != DROP_MAX);
    // Re-arming is allowed from IDLE and from DONE (which discards the capture).
    assign start_capture = g_arm && ((state == ST_IDLE) || (state == ST_DONE));

    // RAM write port; contents are deliberately not reset.
    always_ff @(posedge g_clk) begin
        if (wr_en) begin
            mem[g_wr_count[ADDRWIDTH-1:0]] <= wr_word;
        end
    end

    // Capture/readout state machine with registered outputs and read port.
    always_ff @(posedge g_clk or posedge g_rst) begin
        if (g_rst) begin
            state        <= ST_IDLE;
            g_wr_count   <= '0;
            g_full       <= 1'b0;
            g_drop_count <= '0;
            rd_ptr       <= '0;
            g_rd_data    <= '0;
            g_rd_valid   <= 1'b0;
            g_rd_done    <= 1'b0;
        end else begin
            g_rd_valid <= 1'b0;
            g_rd_done  <= 1'b0;
            if (start_capture) begin
                state        <= ST_CAPTURE;
                g_wr_count   <= '0;
                g_full       <= 1'b0;
                g_drop_count <= '0;
                rd_ptr       <= '0;
            end else begin
                case (state)
                    ST_IDLE: begin
                    end
                    ST_CAPTURE: begin
                        if (g_valid) begin
                            g_wr_count <= wr_count_inc;
                            if (wr_count_inc == DEPTH_CNT) begin
                                g_full <= 1'b1;
                            end
                        end
                        // A stop coincident with an event still keeps that event.
                        if (g_stop || (g_valid && (wr_count_inc == DEPTH_CNT))) begin
                            state <= ST_DONE;
                        end
                    end
                    ST_DONE: begin
                        if (drop_inc) begin
                            g_drop_count <= g_drop_count + 16'd1;
                        end
                        if (g_rd_start) begin
                            rd_ptr <= '0;
                            // Empty capture: report completion without any data word.
                            if (g_wr_count == '0) begin
                                g_rd_done <= 1'b1;
                                state     <= ST_IDLE;
                            end else begin
                                state <= ST_READOUT;
                            end
                        end
                    end
                    ST_READOUT: begin
                        if (drop_inc) begin
                            g_drop_count <= g_drop_count + 16'd1;
                        end
                        if (g_rd_en) begin
                            g_rd_data  <= mem[rd_ptr[ADDRWIDTH-1:0]];
                            g_rd_valid <= 1'b1;
                            rd_ptr     <= rd_ptr + ONE_CNT;
                            if (rd_ptr == last_addr) begin
                                g_rd_done <= 1'b1;
                                state     <= ST_IDLE;
                            end
                        end
                    end
                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule
